pipe_fetch: RTL

- Instruction-fetch stage: produces the instruction word and valid flag consumed by the decode stage (PipeIn of the stage-2 decoder).
- Owns the fetch PC and runs a req/ack protocol to instruction memory.
- Buffers prefetched words in a small FIFO.
- Inserts NOP bubbles (all-zero word; opcode 0 decodes to no assert/no load) on empty buffer or redirect.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/pipe_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, opcode constants, bus source codes
// and the fetch-stage state encoding.
package cpu_pkg;

    // All-zero word: opcode 0 decodes to no assert / no load in decode.
    localparam int unsigned NOP_WORD = 0;

    localparam logic [6:0] OP_MOV = 7'd1;
    localparam logic [6:0] OP_MVI = 7'd2;
    localparam logic [6:0] OP_ADD = 7'd96;
    localparam logic [6:0] OP_SUB = 7'd97;
    localparam logic [6:0] OP_INC = 7'd98;
    localparam logic [6:0] OP_DEC = 7'd99;
    localparam logic [6:0] OP_SHL = 7'd100;
    localparam logic [6:0] OP_SHR = 7'd101;
    localparam logic [6:0] OP_AND = 7'd102;
    localparam logic [6:0] OP_OR  = 7'd103;
    localparam logic [6:0] OP_XOR = 7'd104;
    localparam logic [6:0] OP_NOT = 7'd105;

    localparam logic [3:0] SRC_ALU = 4'd8;
    localparam logic [3:0] SRC_IMM = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {word, pc} entries between memory and decode.
// Ports: clk, rst_n (sync, active low), push/din write, pop reads head_c,
// flush empties, full/empty/count status.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head_c = mem[rd_ptr];
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs req/ack to instruction
// memory, buffers words in fetch_fifo and feeds decode, inserting NOP
// bubbles on empty buffer or redirect.
// Ports: clk, rst_n (sync, active low); MemReq/MemAddr/MemAck/MemData memory
// handshake; Stall from decode; JumpEn/JumpAddr redirect;
// PipeOut/PipeValid/PcOut registered decode interface.
module pipe_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  MemReq,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemData,
    input  logic                  Stall,
    input  logic                  JumpEn,
    input  logic [ADDR_WIDTH-1:0] JumpAddr,
    output logic [DATA_WIDTH-1:0] PipeOut,
    output logic                  PipeValid,
    output logic [ADDR_WIDTH-1:0] PcOut
);

    localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;

    logic          push, pop, flush;
    logic [EW-1:0] head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ack;

    assign MemReq    = req_q;
    assign MemAddr   = addr_q;
    assign PipeOut   = out_q;
    assign PipeValid = valid_q;
    assign PcOut     = pc_out_q;

    // Acks are only meaningful while a request is outstanding.
    assign ack = MemAck && req_q;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    ({MemData, fetch_pc_q}),
        .head_c (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Next-state, PC, request and output-register logic.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        out_d      = out_q;
        valid_d    = valid_q;
        pc_out_d   = pc_out_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (JumpEn) begin
                    // Outstanding request cannot be withdrawn: drain it in FLUSH.
                    if (req_q && !ack) begin
                        state_d = ST_FLUSH;
                    end else begin
                        req_d = 1'b0;
                    end
                end else if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
                    req_d      = 1'b0;
                end else if (!req_q && (fifo_count < CW'(DEPTH))) begin
                    req_d  = 1'b1;
                    addr_d = fetch_pc_q;
                end
            end
            ST_FLUSH: begin
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect beats stall; the newest jump target always wins.
        if (JumpEn) begin
            flush      = 1'b1;
            fetch_pc_d = JumpAddr;
            out_d      = DATA_WIDTH'(NOP_WORD);
            valid_d    = 1'b0;
            pc_out_d   = '0;
        end else if (!Stall) begin
            if (!fifo_empty) begin
                pop      = 1'b1;
                out_d    = head[ADDR_WIDTH +: DATA_WIDTH];
                pc_out_d = head[ADDR_WIDTH-1:0];
                valid_d  = 1'b1;
            end else begin
                out_d    = DATA_WIDTH'(NOP_WORD);
                valid_d  = 1'b0;
                pc_out_d = '0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            pc_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            pc_out_q   <= pc_out_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule
